// File: rtl/object_placer.sv
// Setup-phase placement initiator: proposes candidate coordinates (LFSR or manual cursor),
// checks bounds and collisions against placed objects, then pulses SET or reports failure.
module object_placer #(
  parameter int          X_bits    = 10,
  parameter int          Y_bits    = 9,
  parameter int          X_MAX     = 640,
  parameter int          Y_MAX     = 480,
  parameter int          MARGIN    = 10,
  parameter int          MAX_TRIES = 16,
  parameter logic [31:0] LFSR_SEED = 32'hACE1_2BAD
) (
  input  logic              setup_clk,
  input  logic              RESET,
  input  logic              SETUP_PHASE,
  input  logic              start,
  input  logic              manual,
  input  logic [X_bits-1:0] man_x,
  input  logic [Y_bits-1:0] man_y,
  input  logic              collision,
  output logic [X_bits-1:0] collide_x,
  output logic [Y_bits-1:0] collide_y,
  output logic              SET,
  output logic [X_bits-1:0] out_x,
  output logic [Y_bits-1:0] out_y,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [7:0]        tries
);

  typedef enum logic [2:0] {
    S_IDLE, S_PROPOSE, S_CHECK, S_COMMIT, S_DONE, S_FAIL
  } state_t;

  localparam int CMP_W = ((X_bits > Y_bits) ? X_bits : Y_bits) + 1;
  localparam logic [CMP_W-1:0] X_LO = CMP_W'(MARGIN);
  localparam logic [CMP_W-1:0] X_HI = CMP_W'(X_MAX - 1 - MARGIN);
  localparam logic [CMP_W-1:0] Y_LO = CMP_W'(MARGIN);
  localparam logic [CMP_W-1:0] Y_HI = CMP_W'(Y_MAX - 1 - MARGIN);
  localparam logic [7:0]       TRY_LIMIT = 8'(MAX_TRIES);

  state_t            state, state_nx;
  logic [31:0]       lfsr;
  logic [X_bits-1:0] cand_x;
  logic [Y_bits-1:0] cand_y;
  logic              man_sel;
  logic [X_bits-1:0] man_x_r;
  logic [Y_bits-1:0] man_y_r;
  logic              cand_ok;

  // Taps for x^32 + x^22 + x^2 + x + 1
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  function automatic logic in_bounds(input logic [X_bits-1:0] x, input logic [Y_bits-1:0] y);
    logic [CMP_W-1:0] xw;
    logic [CMP_W-1:0] yw;
    xw = CMP_W'(x);
    yw = CMP_W'(y);
    return (xw >= X_LO) && (xw <= X_HI) && (yw >= Y_LO) && (yw <= Y_HI);
  endfunction

  assign cand_ok = !collision && in_bounds(cand_x, cand_y);

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:    if (start && SETUP_PHASE) state_nx = S_PROPOSE;
      S_PROPOSE: state_nx = SETUP_PHASE ? S_CHECK : S_IDLE;
      S_CHECK: begin
        if (!SETUP_PHASE)                      state_nx = S_IDLE;
        else if (cand_ok)                      state_nx = S_COMMIT;
        else if (!man_sel && tries < TRY_LIMIT) state_nx = S_PROPOSE;
        else                                   state_nx = S_FAIL;
      end
      S_COMMIT:  state_nx = S_DONE;
      S_DONE:    state_nx = S_IDLE;
      S_FAIL:    state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge setup_clk) begin
    if (RESET) begin
      state   <= S_IDLE;
      lfsr    <= LFSR_SEED;
      cand_x  <= '0;
      cand_y  <= '0;
      out_x   <= '0;
      out_y   <= '0;
      tries   <= '0;
      man_sel <= 1'b0;
      man_x_r <= '0;
      man_y_r <= '0;
    end else begin
      state <= state_nx;
      lfsr  <= lfsr_next(lfsr);
      if (state == S_IDLE && start && SETUP_PHASE) begin
        man_sel <= manual;
        man_x_r <= man_x;
        man_y_r <= man_y;
        tries   <= '0;
      end
      // An aborted PROPOSE leaves the candidate and attempt count untouched
      if (state == S_PROPOSE && SETUP_PHASE) begin
        cand_x <= man_sel ? man_x_r : lfsr[X_bits-1:0];
        cand_y <= man_sel ? man_y_r : lfsr[31 -: Y_bits];
        tries  <= tries + 8'd1;
      end
      if (state == S_CHECK && state_nx == S_COMMIT) begin
        out_x <= cand_x;
        out_y <= cand_y;
      end
    end
  end

  assign collide_x = cand_x;
  assign collide_y = cand_y;
  assign SET       = (state == S_COMMIT) && SETUP_PHASE;
  assign done      = (state == S_DONE);
  assign fail      = (state == S_FAIL);
  assign busy      = (state != S_IDLE);

endmodule
